// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit.
//   fwd_sel_t   : execute-stage ALU operand source select
//   RES_LOAD    : result_src encoding that marks a load
//   shadow_e_t  : execute-stage shadow fields
//   shadow_mw_t : memory/writeback-stage shadow fields
//   fwd_select  : forwarding priority function (M over W, x0 never forwards)
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } shadow_e_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } shadow_mw_t;

    // The memory stage holds the younger result, so it wins when both match.
    function automatic fwd_sel_t fwd_select(input logic [4:0]  rs_e,
                                            input shadow_mw_t m,
                                            input shadow_mw_t w);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (rs_e != 5'd0 && m.reg_write && m.rd == rs_e)
            sel = FWD_MEM;
        else if (rs_e != 5'd0 && w.reg_write && w.rd == rs_e)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives decode fields and pc_src_e, receives controls
//   slave  : hazard unit side
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       pc_src_e;
    fwd_sel_t   forward_a_e;
    fwd_sel_t   forward_b_e;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;

    modport master (
        output rs1_d, rs2_d, rd_d, reg_write_d, result_src_d, pc_src_e,
        input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, reg_write_d, result_src_d, pc_src_e,
        output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e
    );

endinterface

// File: rtl/hazard_unit_shadow_pipe.sv
// Shadow copy of the E/M/W destination-register state.
//   clk, rst     : clock, async active-high reset
//   rs1_d..is_load_d : decode-stage fields to capture into E
//   flush_e      : load a bubble (all zero) into E instead of the decode fields
//   e, m, w      : current shadow contents of each stage
module hazard_shadow_pipe
    import hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rd_d,
    input  logic       reg_write_d,
    input  logic       is_load_d,
    input  logic       flush_e,
    output shadow_e_t  e,
    output shadow_mw_t m,
    output shadow_mw_t w
);

    // NOTE: sequential state uses non-blocking assignments so E, M and W all
    // sample their predecessor's value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e <= '0;
            m <= '0;
            w <= '0;
        end else begin
            // A stalled instruction stays in D and sees a bubble ahead of it,
            // so it enters E exactly once, on the following cycle.
            if (flush_e)
                e <= '0;
            else
                e <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                       reg_write: reg_write_d, is_load: is_load_d};
            m <= '{rd: e.rd, reg_write: e.reg_write};
            w <= m;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding controller for the 5-stage RV32I pipeline.
//   clk, rst  : clock, async active-high reset
//   hz        : decode fields / pc_src_e in, forward/stall/flush controls out
//   clr_cnt   : synchronous clear of both performance counters
//   stall_cnt : saturating count of cycles with stall_d=1
//   flush_cnt : saturating count of cycles with pc_src_e=1
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_unit_if.slave     hz,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    shadow_e_t  sh_e;
    shadow_mw_t sh_m;
    shadow_mw_t sh_w;
    logic       lw_stall;
    logic       flush_e_int;

    hazard_shadow_pipe u_shadow (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (hz.rs1_d),
        .rs2_d       (hz.rs2_d),
        .rd_d        (hz.rd_d),
        .reg_write_d (hz.reg_write_d),
        .is_load_d   (hz.result_src_d == RES_LOAD),
        .flush_e     (flush_e_int),
        .e           (sh_e),
        .m           (sh_m),
        .w           (sh_w)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through it can leave a signal unassigned and infer a latch.
    always_comb begin
        lw_stall       = 1'b0;
        hz.forward_a_e = fwd_select(sh_e.rs1, sh_m, sh_w);
        hz.forward_b_e = fwd_select(sh_e.rs2, sh_m, sh_w);
        if (sh_e.is_load && sh_e.rd != 5'd0 &&
            (sh_e.rd == hz.rs1_d || sh_e.rd == hz.rs2_d))
            lw_stall = 1'b1;
        // A taken branch discards the dependent instruction anyway, so the
        // PC must be free to load the target.
        hz.stall_f  = lw_stall && !hz.pc_src_e;
        hz.stall_d  = lw_stall && !hz.pc_src_e;
        hz.flush_d  = hz.pc_src_e;
        flush_e_int = lw_stall || hz.pc_src_e;
        hz.flush_e  = flush_e_int;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall_d && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (hz.pc_src_e && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a directed instruction stream with
// hand-computed controls, then counter saturation/clear and async reset.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             clr_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    hazard_unit_if hz_if ();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hz_if.slave),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       pc;
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
        logic [3:0] scnt, fcnt;
    } vec_t;

    vec_t vecs [16];

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] rsrc, input logic pc);
        hz_if.rs1_d        = rs1;
        hz_if.rs2_d        = rs2;
        hz_if.rd_d         = rd;
        hz_if.reg_write_d  = rw;
        hz_if.result_src_d = rsrc;
        hz_if.pc_src_e     = pc;
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                              input logic stall, input logic fd, input logic fe);
        check({tag, ".fa"},      32'(hz_if.forward_a_e), 32'(fa));
        check({tag, ".fb"},      32'(hz_if.forward_b_e), 32'(fb));
        check({tag, ".stall_f"}, 32'(hz_if.stall_f),     32'(stall));
        check({tag, ".stall_d"}, 32'(hz_if.stall_d),     32'(stall));
        check({tag, ".flush_d"}, 32'(hz_if.flush_d),     32'(fd));
        check({tag, ".flush_e"}, 32'(hz_if.flush_e),     32'(fe));
    endtask

    initial begin
        //           rs1   rs2   rd    rw    rsrc   pc    fa     fb     st    fd    fe    scnt  fcnt
        vecs[0]  = '{5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // add x5
        vecs[1]  = '{5'd5, 5'd3, 5'd8, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // sub x8,x5,x3
        vecs[2]  = '{5'd4, 5'd5, 5'd9, 1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // and x9,x4,x5
        vecs[3]  = '{5'd8, 5'd9, 5'd10,1'b1, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // or x10,x8,x9
        vecs[4]  = '{5'd1, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // lw x6
        vecs[5]  = '{5'd7, 5'd6, 5'd11,1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0}; // add x11,x7,x6 stall
        vecs[6]  = '{5'd7, 5'd6, 5'd11,1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0}; // held add
        vecs[7]  = '{5'd11,5'd0, 5'd12,1'b1, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0}; // sub x12
        vecs[8]  = '{5'd2, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0}; // lw x6
        vecs[9]  = '{5'd6, 5'd1, 5'd13,1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0}; // dep add + branch
        vecs[10] = '{5'd1, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // lw x0
        vecs[11] = '{5'd0, 5'd0, 5'd14,1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // add x14,x0,x0
        vecs[12] = '{5'd1, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // addi x7
        vecs[13] = '{5'd7, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // addi x7,x7
        vecs[14] = '{5'd0, 5'd7, 5'd16,1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // add x16,x0,x7
        vecs[15] = '{5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}; // nop

        rst     = 1'b1;
        clr_cnt = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        #1;
        check_ctrl("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);

        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].rsrc, vecs[i].pc);
            #2;
            check_ctrl($sformatf("v%0d", i), vecs[i].fa, vecs[i].fb,
                       vecs[i].stall, vecs[i].fd, vecs[i].fe);
            check($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].scnt));
            check($sformatf("v%0d.flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fcnt));
            @(posedge clk);
            #1;
        end

        // Plain clear with D holding a nop.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr.stall_cnt", 32'(stall_cnt), 32'd0);
        check("clr.flush_cnt", 32'(flush_cnt), 32'd0);

        // lw x6,0(x6) held in D: stalls every other cycle from cycle 2 on,
        // giving 20 stalls in 41 cycles; the 4-bit counter must stop at 15.
        drive(5'd6, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0);
        repeat (41) @(posedge clk);
        #1;
        check("sat.stall_d", 32'(hz_if.stall_d), 32'd1);
        check("sat.stall_cnt", 32'(stall_cnt), 32'd15);

        // Clear during an active stall: clear beats increment.
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_stall.stall_cnt", 32'(stall_cnt), 32'd0);
        check("clr_stall.bubble_stall_d", 32'(hz_if.stall_d), 32'd0);
        @(posedge clk);
        #1;
        check("restall.stall_d", 32'(hz_if.stall_d), 32'd1);
        check("restall.stall_cnt", 32'(stall_cnt), 32'd0);

        // Asynchronous reset mid-stall, no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check_ctrl("async_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("async_rst.flush_cnt", 32'(flush_cnt), 32'd0);
        hz_if.pc_src_e = 1'b1;
        #1;
        check_ctrl("rst_branch", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
